// File: rtl/chime_pkg.sv
// Shared types and sizing helpers for the warning chime FSM and its timer.
package chime_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRACE    = 3'd1,
        BEEP_ON  = 3'd2,
        BEEP_OFF = 3'd3,
        TIMEOUT  = 3'd4
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter that restarts on clr and flags the cycle whose count equals len.
module cycle_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] len,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else
            count <= count + W'(1);
    end

    // len is the terminal count (cycles-1), so done marks the last cycle.
    assign done = (count == len);

endmodule

// File: rtl/warning_chime.sv
// Turns a persistent Alarm into a grace delay, a bounded beep burst and a
// steady lamp; Ack or burst completion mutes, an Alarm drop returns to idle.
module warning_chime
    import chime_pkg::*;
#(
    parameter int unsigned GRACE_CYC = 8,
    parameter int unsigned ON_CYC    = 4,
    parameter int unsigned OFF_CYC   = 4,
    parameter int unsigned MAX_BEEPS = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Alarm,
    input  logic                                Ack,
    output logic                                Buzzer,
    output logic                                Lamp,
    output logic                                Muted,
    output logic [cnt_width(MAX_BEEPS+1)-1:0]   BeepCount
);

    localparam int unsigned TW = cnt_width(max3(GRACE_CYC, ON_CYC, OFF_CYC));
    localparam int unsigned BW = cnt_width(MAX_BEEPS + 1);

    state_t          state, nxt;
    logic [BW-1:0]   cnt_nxt;
    logic [TW-1:0]   len, tcount;
    logic            tdone, tclr;

    always_comb begin
        len = '0;
        case (state)
            GRACE:    len = TW'(GRACE_CYC - 1);
            BEEP_ON:  len = TW'(ON_CYC - 1);
            BEEP_OFF: len = TW'(OFF_CYC - 1);
            default:  len = '0;
        endcase
    end

    // Every condition that can leave the current state also restarts the
    // timer; IDLE and TIMEOUT keep it parked at zero.
    assign tclr = (state == IDLE) || (state == TIMEOUT) || !Alarm || Ack || tdone;

    cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tclr),
        .len   (len),
        .count (tcount),
        .done  (tdone)
    );

    always_comb begin
        nxt     = state;
        cnt_nxt = BeepCount;
        if (state == IDLE) begin
            if (Alarm) begin
                nxt     = GRACE;
                cnt_nxt = '0;
            end
        end else if (!Alarm) begin
            nxt     = IDLE;
            cnt_nxt = '0;
        end else if (Ack && state != TIMEOUT) begin
            nxt = TIMEOUT;
        end else if (tdone) begin
            case (state)
                GRACE:   nxt = BEEP_ON;
                BEEP_ON: begin
                    nxt     = BEEP_OFF;
                    cnt_nxt = BeepCount + BW'(1);
                end
                BEEP_OFF: nxt = (BeepCount == BW'(MAX_BEEPS)) ? TIMEOUT : BEEP_ON;
                default:  nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            BeepCount <= '0;
            Buzzer    <= 1'b0;
            Lamp      <= 1'b0;
            Muted     <= 1'b0;
        end else begin
            state     <= nxt;
            BeepCount <= cnt_nxt;
            Buzzer    <= (nxt == BEEP_ON);
            Lamp      <= (nxt != IDLE);
            Muted     <= (nxt == TIMEOUT);
        end
    end

endmodule

// File: tb/tb_warning_chime.sv
// Directed bench for warning_chime with an episode-timeline reference model.
module tb_warning_chime;

    localparam int G   = 8;
    localparam int ON  = 4;
    localparam int OFF = 4;
    localparam int MB  = 3;
    localparam int P   = ON + OFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Alarm = 1'b1;
    logic       Ack = 1'b0;
    logic       Buzzer, Lamp, Muted;
    logic [1:0] BeepCount;

    int n_cmp = 0;
    int n_bad = 0;

    warning_chime #(.GRACE_CYC(G), .ON_CYC(ON), .OFF_CYC(OFF), .MAX_BEEPS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .Alarm     (Alarm),
        .Ack       (Ack),
        .Buzzer    (Buzzer),
        .Lamp      (Lamp),
        .Muted     (Muted),
        .BeepCount (BeepCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the episode timeline measured in edges.
    bit mvalid = 0;
    bit active = 0;
    bit acked  = 0;
    int t      = 0;
    int frozen = 0;
    int m_buz = 0, m_lamp = 0, m_mute = 0, m_cnt = 0;

    function automatic bit in_to(input int tt);
        return (tt >= G) && ((tt - G) >= MB * P);
    endfunction

    function automatic int beeps_at(input int tt);
        int u;
        if (tt < G) return 0;
        u = tt - G;
        if (u >= MB * P) return MB;
        return (u / P) + (((u % P) >= ON) ? 1 : 0);
    endfunction

    function automatic int buzzing(input int tt);
        if (tt < G || in_to(tt)) return 0;
        return (((tt - G) % P) < ON) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            active = 0;
            mvalid = 1;
        end else if (!active) begin
            if (Alarm) begin
                active = 1;
                acked  = 0;
                t      = 0;
            end
        end else if (!Alarm) begin
            active = 0;
        end else if (!acked && Ack && !in_to(t)) begin
            acked  = 1;
            frozen = beeps_at(t);
        end else begin
            t++;
        end
        if (!active) begin
            m_buz = 0; m_lamp = 0; m_mute = 0; m_cnt = 0;
        end else if (acked) begin
            m_buz = 0; m_lamp = 1; m_mute = 1; m_cnt = frozen;
        end else begin
            m_buz  = buzzing(t);
            m_lamp = 1;
            m_mute = in_to(t) ? 1 : 0;
            m_cnt  = beeps_at(t);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_buzzer", 32'(Buzzer), m_buz);
            chk("model_lamp",   32'(Lamp),   m_lamp);
            chk("model_muted",  32'(Muted),  m_mute);
            chk("model_count",  32'(BeepCount), m_cnt);
        end
    end

    task automatic cyc(input logic r, input logic a, input logic k);
        rst   = r;
        Alarm = a;
        Ack   = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_out(input string name);
        chk({name, "_buz"},  32'(Buzzer), 0);
        chk({name, "_lamp"}, 32'(Lamp), 0);
        chk({name, "_mute"}, 32'(Muted), 0);
        chk({name, "_cnt"},  32'(BeepCount), 0);
    endtask

    initial begin
        // Reset held two cycles with Alarm high, then re-arm.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0);
            idle_out("reset");
        end
        cyc(0, 1, 0);
        chk("rearm_lamp", 32'(Lamp), 1);
        chk("rearm_buz",  32'(Buzzer), 0);
        cyc(0, 0, 0);
        idle_out("rearm_drop");

        // Short alarm: five cycles high, then low.
        for (int e = 0; e < 7; e++) begin
            cyc(0, (e < 5) ? 1'b1 : 1'b0, 0);
            chk("short_lamp", 32'(Lamp), (e < 5) ? 1 : 0);
            chk("short_buz",  32'(Buzzer), 0);
            chk("short_cnt",  32'(BeepCount), 0);
        end

        // Full episode with default timing.
        for (int e = 0; e < 36; e++) begin
            cyc(0, 1, 0);
            chk("full_buz", 32'(Buzzer),
                ((e >= 8 && e <= 11) || (e >= 16 && e <= 19) || (e >= 24 && e <= 27)) ? 1 : 0);
            chk("full_cnt", 32'(BeepCount), (e < 12) ? 0 : (e < 20) ? 1 : (e < 28) ? 2 : 3);
            chk("full_mute", 32'(Muted), (e >= 32) ? 1 : 0);
            chk("full_lamp", 32'(Lamp), 1);
        end
        cyc(0, 0, 0);
        idle_out("full_drop");

        // Acknowledge raised after edge 17, sampled at edge 18.
        for (int e = 0; e < 30; e++) begin
            cyc(0, 1, (e == 18) ? 1'b1 : 1'b0);
            if (e >= 18) begin
                chk("ack_buz",  32'(Buzzer), 0);
                chk("ack_mute", 32'(Muted), 1);
                chk("ack_cnt",  32'(BeepCount), 1);
                chk("ack_lamp", 32'(Lamp), 1);
            end
        end
        cyc(0, 1, 1);
        chk("ack_in_timeout", 32'(Muted), 1);
        cyc(0, 0, 0);
        idle_out("ack_drop");

        // Alarm drop together with Ack during the first BEEP_OFF.
        for (int e = 0; e < 14; e++) cyc(0, 1, 0);
        chk("simul_pre_cnt", 32'(BeepCount), 1);
        cyc(0, 0, 1);
        idle_out("simul");
        for (int e = 0; e < 10; e++) begin
            cyc(0, 1, 0);
            chk("simul_regrace_buz", 32'(Buzzer), (e >= 8) ? 1 : 0);
            chk("simul_regrace_cnt", 32'(BeepCount), 0);
        end
        cyc(0, 0, 0);

        // Reset at edge 10 mid-episode, Alarm kept high.
        for (int e = 0; e < 22; e++) begin
            cyc((e == 10) ? 1'b1 : 1'b0, 1, 0);
            if (e == 10) idle_out("midrst");
            if (e == 11) chk("midrst_lamp", 32'(Lamp), 1);
            if (e >= 11) chk("midrst_buz", 32'(Buzzer), (e >= 19) ? 1 : 0);
        end
        cyc(0, 0, 0);
        idle_out("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
